// File: rtl/uart_parity_pkg.sv
// Shared definitions for the UART parity engine: mode encodings, RX state
// enum and the parity function used by both the TX and RX paths.
package uart_parity_pkg;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } rx_state_e;

    // acc is the XOR of all data bits of the word.
    function automatic logic par_expected(input logic acc, input logic [1:0] mode);
        case (mode)
            PAR_EVEN: return acc;
            PAR_ODD:  return ~acc;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_parity_engine_if.sv
// Handshake/status bundle between the UART core and the parity engine.
interface uart_parity_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ERR_CNT_W  = 8
);
    logic                  par_en;
    logic [1:0]            par_mode;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_free;
    logic                  tx_par_bit;
    logic                  rx_start;
    logic                  rx_bit_valid;
    logic                  rx_bit;
    logic                  rx_busy;
    logic                  rx_done;
    logic                  rx_par_err;
    logic                  err_sticky;
    logic                  err_clr;
    logic [ERR_CNT_W-1:0]  err_cnt;

    modport master (
        output par_en, par_mode, tx_data, tx_valid, tx_free,
               rx_start, rx_bit_valid, rx_bit, err_clr,
        input  tx_par_bit, rx_busy, rx_done, rx_par_err, err_sticky, err_cnt
    );

    modport slave (
        input  par_en, par_mode, tx_data, tx_valid, tx_free,
               rx_start, rx_bit_valid, rx_bit, err_clr,
        output tx_par_bit, rx_busy, rx_done, rx_par_err, err_sticky, err_cnt
    );
endinterface

// File: rtl/uart_parity_rx_chk.sv
// Serial RX parity checker: frame FSM, running XOR of data bits, bit counter
// and the parity mode latched at the start bit.
module uart_parity_rx_chk
    import uart_parity_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       par_en,
    input  logic [1:0] par_mode,
    input  logic       rx_start,
    input  logic       rx_bit_valid,
    input  logic       rx_bit,
    output logic       rx_busy,
    output logic       rx_done,
    output logic       rx_par_err,
    output logic       par_err_evt
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_state_e        state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             last_bit;

    assign last_bit = (cnt_q == LAST_BIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            mode_q  <= PAR_EVEN;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // A start bit restarts the frame from any state and swallows a coincident bit.
    always_comb begin
        state_d = state_q;
        if (rx_start) begin
            state_d = DATA;
        end else if (rx_bit_valid) begin
            case (state_q)
                DATA:    if (last_bit) state_d = en_q ? PAR : IDLE;
                PAR:     state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        en_d   = en_q;
        mode_d = mode_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        if (rx_start) begin
            acc_d  = 1'b0;
            cnt_d  = '0;
            en_d   = par_en;
            mode_d = par_mode;
        end else if (rx_bit_valid) begin
            case (state_q)
                DATA: begin
                    acc_d = acc_q ^ rx_bit;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_bit && !en_q) done_d = 1'b1;
                end
                PAR: begin
                    done_d = 1'b1;
                    err_d  = (rx_bit != par_expected(acc_q, mode_q));
                end
                default: ;
            endcase
        end
    end

    assign rx_busy     = (state_q != IDLE);
    assign rx_done     = done_q;
    assign rx_par_err  = err_q;
    assign par_err_evt = err_d;

endmodule

// File: rtl/uart_parity_engine.sv
// UART parity engine top: TX parity register, RX checker and the error
// sticky flag / saturating counter read by the register file.
module uart_parity_engine
    import uart_parity_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_parity_engine_if.slave  bus
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic                 tx_par_q, tx_par_d;
    logic                 sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 par_err_evt;

    uart_parity_rx_chk #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rx_chk (
        .clk          (clk),
        .rst          (rst),
        .par_en       (bus.par_en),
        .par_mode     (bus.par_mode),
        .rx_start     (bus.rx_start),
        .rx_bit_valid (bus.rx_bit_valid),
        .rx_bit       (bus.rx_bit),
        .rx_busy      (bus.rx_busy),
        .rx_done      (bus.rx_done),
        .rx_par_err   (bus.rx_par_err),
        .par_err_evt  (par_err_evt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_par_q  <= 1'b0;
            sticky_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            tx_par_q  <= tx_par_d;
            sticky_q  <= sticky_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        tx_par_d = tx_par_q;
        if (bus.tx_valid && bus.tx_free) begin
            tx_par_d = bus.par_en ? par_expected(^bus.tx_data, bus.par_mode) : 1'b0;
        end
    end

    // Clear is applied first so a coincident error still counts as one.
    always_comb begin
        sticky_d  = sticky_q;
        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            sticky_d  = 1'b0;
            err_cnt_d = '0;
        end
        if (par_err_evt) begin
            sticky_d = 1'b1;
            if (err_cnt_d != CNT_MAX) err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
        end
    end

    assign bus.tx_par_bit = tx_par_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Self-checking bench for uart_parity_engine: directed TX loads plus an RX
// scoreboard of expected per-frame results popped on each rx_done.
module tb_uart_parity_engine;

    localparam int DW      = 8;
    localparam int EW      = 2;
    localparam int CNT_MAX = (1 << EW) - 1;

    typedef struct packed {
        logic          par_err;
        logic          sticky;
        logic [EW-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   check_count = 0;
    int   error_count = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   m_cnt    = 0;
    logic m_sticky = 1'b0;
    logic tx_model = 1'b0;

    uart_parity_engine_if #(.DATA_WIDTH(DW), .ERR_CNT_W(EW)) bus ();

    uart_parity_engine #(.DATA_WIDTH(DW), .ERR_CNT_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic modelPar(input logic [DW-1:0] d, input logic [1:0] m);
        logic p;
        p = ($countones(d) % 2) == 1;
        case (m)
            2'b00:   return p;
            2'b01:   return !p;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic err, input logic clr);
        exp_t e;
        if (clr) begin
            m_cnt    = 0;
            m_sticky = 1'b0;
        end
        if (err) begin
            m_sticky = 1'b1;
            if (m_cnt != CNT_MAX) m_cnt++;
        end
        e.par_err = err;
        e.sticky  = m_sticky;
        e.cnt     = m_cnt[EW-1:0];
        sb_q.push_back(e);
    endtask

    task automatic applyTxStimulus(input string tag, input logic [DW-1:0] data,
                                   input logic en, input logic [1:0] mode, input logic free);
        bus.tx_data  = data;
        bus.par_en   = en;
        bus.par_mode = mode;
        bus.tx_valid = 1'b1;
        bus.tx_free  = free;
        if (free) tx_model = en ? modelPar(data, mode) : 1'b0;
        nextCycle();
        bus.tx_valid = 1'b0;
        bus.tx_free  = 1'b1;
        checkOutput(tag, 32'(bus.tx_par_bit), 32'(tx_model));
    endtask

    // One full RX frame; mode/enable are scrambled after the start bit to show they are latched.
    task automatic applyStimulus(input logic [DW-1:0] data, input logic pbit,
                                 input logic en, input logic [1:0] mode, input logic clr);
        logic err;
        err = en && (pbit !== modelPar(data, mode));
        bus.par_en       = en;
        bus.par_mode     = mode;
        bus.rx_start     = 1'b1;
        bus.rx_bit_valid = 1'b1;
        bus.rx_bit       = 1'b1;
        nextCycle();
        bus.rx_start = 1'b0;
        bus.par_en   = !en;
        bus.par_mode = ~mode;
        checkOutput("rx_busy_start", 32'(bus.rx_busy), 1);
        for (int i = 0; i < DW; i++) begin
            bus.rx_bit       = data[i];
            bus.rx_bit_valid = 1'b1;
            if (i == DW - 1 && !en) pushExp(1'b0, 1'b0);
            nextCycle();
        end
        if (en) begin
            bus.rx_bit  = pbit;
            bus.err_clr = clr;
            pushExp(err, clr);
            nextCycle();
            bus.err_clr = 1'b0;
        end
        bus.rx_bit_valid = 1'b0;
        checkOutput("rx_busy_end", 32'(bus.rx_busy), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.rx_done) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'(bus.rx_done), 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("rx_par_err", 32'(bus.rx_par_err), 32'(mon_e.par_err));
                    checkOutput("err_sticky", 32'(bus.err_sticky), 32'(mon_e.sticky));
                    checkOutput("err_cnt", 32'(bus.err_cnt), 32'(mon_e.cnt));
                end
            end else if (bus.rx_par_err) begin
                checkOutput("par_err_without_done", 32'(bus.rx_par_err), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst              = 1'b0;
        bus.par_en       = 1'b0;
        bus.par_mode     = 2'b00;
        bus.tx_data      = '0;
        bus.tx_valid     = 1'b0;
        bus.tx_free      = 1'b1;
        bus.rx_start     = 1'b0;
        bus.rx_bit_valid = 1'b0;
        bus.rx_bit       = 1'b0;
        bus.err_clr      = 1'b0;
        #12;
        checkOutput("rst_tx_par_bit", 32'(bus.tx_par_bit), 0);
        checkOutput("rst_rx_busy", 32'(bus.rx_busy), 0);
        checkOutput("rst_rx_done", 32'(bus.rx_done), 0);
        checkOutput("rst_rx_par_err", 32'(bus.rx_par_err), 0);
        checkOutput("rst_err_sticky", 32'(bus.err_sticky), 0);
        checkOutput("rst_err_cnt", 32'(bus.err_cnt), 0);
        nextCycle();
        rst = 1'b1;
        nextCycle();

        applyTxStimulus("tx_even_a5", 8'hA5, 1'b1, 2'b00, 1'b1);
        applyTxStimulus("tx_odd_a5", 8'hA5, 1'b1, 2'b01, 1'b1);
        applyTxStimulus("tx_even_07", 8'h07, 1'b1, 2'b00, 1'b1);
        applyTxStimulus("tx_space_ff", 8'hFF, 1'b1, 2'b11, 1'b1);
        applyTxStimulus("tx_mark_00", 8'h00, 1'b1, 2'b10, 1'b1);
        applyTxStimulus("tx_space_5a", 8'h5A, 1'b1, 2'b11, 1'b1);
        applyTxStimulus("tx_hold_not_free", 8'hA5, 1'b1, 2'b01, 1'b0);
        bus.par_mode = 2'b10;
        nextCycle();
        checkOutput("tx_hold_mode_change", 32'(bus.tx_par_bit), 32'(tx_model));
        applyTxStimulus("tx_mark_ff", 8'hFF, 1'b1, 2'b10, 1'b1);
        applyTxStimulus("tx_disabled", 8'h07, 1'b0, 2'b10, 1'b1);

        applyStimulus(8'h07, 1'b1, 1'b1, 2'b00, 1'b0);
        nextCycle();
        applyStimulus(8'h07, 1'b0, 1'b1, 2'b00, 1'b0);
        nextCycle();

        // Aborted frame followed by a clean odd-parity frame.
        bus.par_en   = 1'b1;
        bus.par_mode = 2'b00;
        bus.rx_start = 1'b1;
        nextCycle();
        bus.rx_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rx_bit_valid = 1'b1;
            bus.rx_bit       = i[0];
            nextCycle();
        end
        applyStimulus(8'h5A, 1'b1, 1'b1, 2'b01, 1'b0);

        applyStimulus(8'h3C, 1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(8'h81, 1'b0, 1'b1, 2'b00, 1'b0);

        bus.rx_bit_valid = 1'b1;
        bus.rx_bit       = 1'b1;
        repeat (3) nextCycle();
        bus.rx_bit_valid = 1'b0;
        checkOutput("idle_ignores_bits", 32'(bus.rx_busy), 0);

        bus.err_clr = 1'b1;
        nextCycle();
        bus.err_clr = 1'b0;
        m_cnt    = 0;
        m_sticky = 1'b0;
        checkOutput("clr_sticky", 32'(bus.err_sticky), 0);
        checkOutput("clr_cnt", 32'(bus.err_cnt), 0);

        applyStimulus(8'h07, 1'b0, 1'b1, 2'b00, 1'b0);
        applyStimulus(8'h07, 1'b1, 1'b1, 2'b01, 1'b0);
        applyStimulus(8'h55, 1'b0, 1'b1, 2'b10, 1'b0);
        applyStimulus(8'hAA, 1'b1, 1'b1, 2'b11, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b1, 2'b00, 1'b0);
        nextCycle();
        checkOutput("sat_cnt", 32'(bus.err_cnt), CNT_MAX);

        applyStimulus(8'h07, 1'b0, 1'b1, 2'b00, 1'b1);
        nextCycle();
        checkOutput("collision_cnt", 32'(bus.err_cnt), 1);
        checkOutput("collision_sticky", 32'(bus.err_sticky), 1);

        applyTxStimulus("tx_mark_pre_reset", 8'h00, 1'b1, 2'b10, 1'b1);

        // Park the RX FSM in the parity state, then hit reset between edges.
        bus.par_en   = 1'b1;
        bus.par_mode = 2'b00;
        bus.rx_start = 1'b1;
        nextCycle();
        bus.rx_start = 1'b0;
        for (int i = 0; i < DW; i++) begin
            bus.rx_bit_valid = 1'b1;
            bus.rx_bit       = 1'b1;
            nextCycle();
        end
        bus.rx_bit_valid = 1'b0;
        checkOutput("pre_reset_busy", 32'(bus.rx_busy), 1);
        #3;
        rst = 1'b0;
        #1;
        m_cnt    = 0;
        m_sticky = 1'b0;
        checkOutput("async_rst_busy", 32'(bus.rx_busy), 0);
        checkOutput("async_rst_tx_par_bit", 32'(bus.tx_par_bit), 0);
        checkOutput("async_rst_err_cnt", 32'(bus.err_cnt), 0);
        checkOutput("async_rst_err_sticky", 32'(bus.err_sticky), 0);
        checkOutput("async_rst_rx_done", 32'(bus.rx_done), 0);
        nextCycle();
        nextCycle();
        rst = 1'b1;
        bus.rx_bit_valid = 1'b1;
        bus.rx_bit       = 1'b0;
        repeat (3) nextCycle();
        bus.rx_bit_valid = 1'b0;
        checkOutput("post_reset_busy", 32'(bus.rx_busy), 0);
        checkOutput("post_reset_err_cnt", 32'(bus.err_cnt), 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) nextCycle();
        checkOutput("sb_drain", 32'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
